// File: rtl/pong_pkg.sv
// Shared encodings and default timings for the Pong buzzer scheduler.
package pong_pkg;

    localparam int unsigned SRC_W   = 2;
    localparam int unsigned NUM_SRC = 3;

    localparam logic [SRC_W-1:0] SRC_NONE  = 2'd0;
    localparam logic [SRC_W-1:0] SRC_WALL  = 2'd1;
    localparam logic [SRC_W-1:0] SRC_PAD   = 2'd2;
    localparam logic [SRC_W-1:0] SRC_SCORE = 2'd3;

    localparam int unsigned PAD_TICKS_DEF   = 6;
    localparam int unsigned WALL_TICKS_DEF  = 4;
    localparam int unsigned SCORE_TICKS_DEF = 32;
    localparam int unsigned SCORE_PHASE_DEF = 4;

    // State codes equal the source codes so active_src is the state itself.
    typedef enum logic [SRC_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_WALL  = 2'd1,
        ST_PAD   = 2'd2,
        ST_SCORE = 2'd3
    } state_e;

    // Request/pending vectors: bit 0 wall, bit 1 pad, bit 2 score.
    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_W-1:0] src);
        logic [NUM_SRC-1:0] oh;
        oh = '0;
        case (src)
            SRC_WALL:  oh = 3'b001;
            SRC_PAD:   oh = 3'b010;
            SRC_SCORE: oh = 3'b100;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/pong_prio_pick.sv
// Fixed-priority picker: score over pad over wall, among live requests and pending flags.
module pong_prio_pick
    import pong_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [NUM_SRC-1:0] pend_i,
    output logic [SRC_W-1:0]   win_c
);

    logic [NUM_SRC-1:0] cand;

    always_comb begin
        cand  = req_i | pend_i;
        win_c = SRC_NONE;
        if (cand[2]) begin
            win_c = SRC_SCORE;
        end else if (cand[1]) begin
            win_c = SRC_PAD;
        end else if (cand[0]) begin
            win_c = SRC_WALL;
        end
    end

endmodule

// File: rtl/pong_sound_scheduler.sv
// Buzzer arbiter: grants one sound at a time by fixed priority, times it in game
// ticks, keeps one-deep pending flags and freezes while the game is paused.
module pong_sound_scheduler
    import pong_pkg::*;
#(
    parameter int unsigned PAD_TICKS   = PAD_TICKS_DEF,
    parameter int unsigned WALL_TICKS  = WALL_TICKS_DEF,
    parameter int unsigned SCORE_TICKS = SCORE_TICKS_DEF,
    parameter int unsigned SCORE_PHASE = SCORE_PHASE_DEF
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             game_tick,
    input  logic             pause,
    input  logic             pad_tone,
    input  logic             wall_tone,
    input  logic             req_pad,
    input  logic             req_wall,
    input  logic             req_score,
    output logic             buzzer,
    output logic             busy,
    output logic [SRC_W-1:0] active_src
);

    localparam int unsigned CNT_W = $clog2(SCORE_TICKS) + 1;
    localparam int unsigned PH_W  = $clog2(SCORE_PHASE) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               tone_sel_q, tone_sel_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic               buzzer_q, buzzer_d;

    logic [NUM_SRC-1:0] req_v;
    logic [NUM_SRC-1:0] cur_oh;
    logic [NUM_SRC-1:0] arb_req;
    logic [SRC_W-1:0]   win;
    logic               playing;
    logic               ending;

    function automatic logic [CNT_W-1:0] ticks_of(input logic [SRC_W-1:0] src);
        logic [CNT_W-1:0] t;
        case (src)
            SRC_WALL:  t = CNT_W'(WALL_TICKS);
            SRC_PAD:   t = CNT_W'(PAD_TICKS);
            SRC_SCORE: t = CNT_W'(SCORE_TICKS);
            default:   t = '0;
        endcase
        return t;
    endfunction

    // A re-request of the playing source reloads it instead of entering arbitration,
    // except on the end edge where it competes like any other request.
    always_comb begin
        req_v   = pause ? '0 : {req_score, req_pad, req_wall};
        cur_oh  = src_onehot(SRC_W'(state_q));
        playing = (state_q != ST_IDLE);
        ending  = playing && game_tick && !pause && (cnt_q == CNT_W'(1));
        arb_req = (playing && !ending) ? (req_v & ~cur_oh) : req_v;
    end

    pong_prio_pick u_pick (
        .req_i  (arb_req),
        .pend_i (pend_q),
        .win_c  (win)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        tone_sel_d = tone_sel_q;
        pend_d     = pend_q;
        if (!pause) begin
            pend_d = pend_q | arb_req;
            if (!playing || ending || (win > SRC_W'(state_q))) begin
                if (win != SRC_NONE) begin
                    state_d    = state_e'(win);
                    cnt_d      = ticks_of(win);
                    phase_d    = '0;
                    tone_sel_d = 1'b0;
                    pend_d     = pend_d & ~src_onehot(win);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end else if ((req_v & cur_oh) != '0) begin
                cnt_d      = ticks_of(SRC_W'(state_q));
                phase_d    = '0;
                tone_sel_d = 1'b0;
            end else if (game_tick) begin
                cnt_d = cnt_q - CNT_W'(1);
                if (state_q == ST_SCORE) begin
                    if (phase_q == PH_W'(SCORE_PHASE - 1)) begin
                        phase_d    = '0;
                        tone_sel_d = ~tone_sel_q;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
        end
    end

    // Buzzer follows the tone of the registered state, one cycle behind it.
    always_comb begin
        buzzer_d = 1'b0;
        if (!pause) begin
            case (state_q)
                ST_WALL:  buzzer_d = wall_tone;
                ST_PAD:   buzzer_d = pad_tone;
                ST_SCORE: buzzer_d = tone_sel_q ? wall_tone : pad_tone;
                default:  buzzer_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            phase_q    <= '0;
            tone_sel_q <= 1'b0;
            pend_q     <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            tone_sel_q <= tone_sel_d;
            pend_q     <= pend_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign buzzer     = buzzer_q;
    assign busy       = (state_q != ST_IDLE);
    assign active_src = SRC_W'(state_q);

endmodule

// File: tb/tb_pong_sound_scheduler.sv
// Directed bench for pong_sound_scheduler: a per-cycle vector table plus
// hand-written sequences for preemption, pause, reload and reset.
module tb_pong_sound_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_tick;
    logic       pause;
    logic       pad_tone;
    logic       wall_tone;
    logic       req_pad;
    logic       req_wall;
    logic       req_score;
    logic       buzzer;
    logic       busy;
    logic [1:0] active_src;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] cyc = '0;
    logic       prev_pad;
    logic       prev_wall;

    typedef struct {
        bit       tk;
        bit       rp;
        bit       rw;
        bit       rs;
        bit       exp_busy;
        bit [1:0] exp_src;
    } vec_t;

    vec_t vecs[$];

    pong_sound_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .game_tick  (game_tick),
        .pause      (pause),
        .pad_tone   (pad_tone),
        .wall_tone  (wall_tone),
        .req_pad    (req_pad),
        .req_wall   (req_wall),
        .req_score  (req_score),
        .buzzer     (buzzer),
        .busy       (busy),
        .active_src (active_src)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // One clock cycle; tones are free-running squares the bench owns.
    task automatic step();
        prev_pad  = pad_tone;
        prev_wall = wall_tone;
        @(posedge clk);
        #1;
        cyc       = cyc + 8'd1;
        pad_tone  = cyc[2];
        wall_tone = cyc[0];
    endtask

    task automatic tick();
        game_tick = 1'b1;
        step();
        game_tick = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input int n, input bit tk, input bit rp, input bit rw,
                                input bit rs, input bit eb, input bit [1:0] es);
        vec_t v;
        v.tk = tk; v.rp = rp; v.rw = rw; v.rs = rs; v.exp_busy = eb; v.exp_src = es;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    function automatic bit tone_for(input bit [1:0] src, input bit sel);
        case (src)
            2'd1:    return prev_wall;
            2'd2:    return prev_pad;
            2'd3:    return sel ? prev_wall : prev_pad;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        bit [1:0] prev_src;

        rst = 1'b1; game_tick = 1'b0; pause = 1'b0;
        req_pad = 1'b0; req_wall = 1'b0; req_score = 1'b0;
        pad_tone = 1'b0; wall_tone = 1'b0;
        step(); step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_src", int'(active_src), 0);
        chk("reset_buzzer", int'(buzzer), 0);
        rst = 1'b0;

        //  n  tk rp rw rs busy src
        add(3, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 1, 1);   // wall alone
        add(3, 1, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 0);   // ends on 4th tick
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 1, 2);   // pad wins, wall pended
        add(5, 1, 0, 0, 0, 1, 2);
        add(1, 1, 0, 0, 0, 1, 1);   // wall follows with no gap
        add(3, 1, 0, 0, 0, 1, 1);
        add(1, 1, 1, 0, 0, 1, 2);   // request on end edge is granted
        add(5, 1, 0, 0, 0, 1, 2);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);

        prev_src = 2'd0;
        foreach (vecs[i]) begin
            game_tick = vecs[i].tk;
            req_pad   = vecs[i].rp;
            req_wall  = vecs[i].rw;
            req_score = vecs[i].rs;
            step();
            game_tick = 1'b0; req_pad = 1'b0; req_wall = 1'b0; req_score = 1'b0;
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_src", i), int'(active_src), int'(vecs[i].exp_src));
            chk($sformatf("vec%0d_buzzer", i), int'(buzzer), int'(tone_for(prev_src, 1'b0)));
            prev_src = vecs[i].exp_src;
        end

        // Score preempts a wall sound and alternates tones every 4 ticks.
        req_wall = 1'b1; step(); req_wall = 1'b0;
        chk("pre_wall_src", int'(active_src), 1);
        tick(); step(); tick(); step();
        req_score = 1'b1; step(); req_score = 1'b0;
        chk("preempt_src", int'(active_src), 3);
        step();
        chk("score_t0_buzzer", int'(buzzer), int'(prev_pad));
        for (int t = 1; t <= 32; t++) begin
            tick();
            step();
            if (t < 32) begin
                chk($sformatf("score_t%0d_src", t), int'(active_src), 3);
                chk($sformatf("score_t%0d_buzzer", t), int'(buzzer),
                    int'(tone_for(2'd3, 1'((t / 4) % 2))));
            end else begin
                chk("score_end_src", int'(active_src), 0);
                chk("score_end_buzzer", int'(buzzer), 0);
            end
        end
        step(); step();
        chk("wall_not_resumed", int'(busy), 0);

        // Pause freezes a pad sound mid-way; requests during pause are dropped.
        req_pad = 1'b1; step(); req_pad = 1'b0;
        tick(); tick(); tick();
        pause = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            game_tick = (i % 2 == 1);
            req_wall  = (i == 500);
            step();
            if (i % 100 == 0) begin
                chk($sformatf("pause%0d_buzzer", i), int'(buzzer), 0);
                chk($sformatf("pause%0d_src", i), int'(active_src), 2);
            end
        end
        pause = 1'b0; game_tick = 1'b0; req_wall = 1'b0;
        step();
        chk("unpause_buzzer", int'(buzzer), int'(prev_pad));
        tick(); chk("unpause_t1_src", int'(active_src), 2);
        tick(); chk("unpause_t2_src", int'(active_src), 2);
        tick(); chk("unpause_t3_src", int'(active_src), 0);
        step(); step();
        chk("paused_req_dropped", int'(active_src), 0);

        // Pad re-requested on its 4th tick reloads the full length.
        req_pad = 1'b1; step(); req_pad = 1'b0;
        tick(); tick(); tick();
        game_tick = 1'b1; req_pad = 1'b1; step(); game_tick = 1'b0; req_pad = 1'b0;
        chk("reload_src", int'(active_src), 2);
        for (int t = 1; t <= 5; t++) tick();
        chk("reload_t5_src", int'(active_src), 2);
        tick();
        chk("reload_end_src", int'(active_src), 0);
        for (int i = 0; i < 20; i++) step();
        chk("no_second_pad", int'(busy), 0);

        // Reset mid-score with wall pending clears everything.
        req_score = 1'b1; step(); req_score = 1'b0;
        chk("rst_pre_score", int'(active_src), 3);
        tick();
        req_wall = 1'b1; step(); req_wall = 1'b0;
        chk("rst_pre_wall_pended", int'(active_src), 3);
        tick(); tick();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_src", int'(active_src), 0);
        chk("rst_mid_buzzer", int'(buzzer), 0);
        for (int t = 0; t < 40; t++) tick();
        chk("rst_no_pending_src", int'(active_src), 0);
        chk("rst_no_pending_buzzer", int'(buzzer), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
